// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register implemented as a two-entry skid buffer, with a
// forwarding tap on the head entry and a saturating stall-cycle counter.
module ex_mem_pipe #(
  parameter int DATA_W   = 64,
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              memWrite_E_EX,
  input  logic              MemToReg_EX,
  input  logic              regWrite_E_EX,
  input  logic              mem_read_EX,
  input  logic [DATA_W-1:0] ALU_out_EX,
  input  logic [DATA_W-1:0] mem_Din_EX,
  input  logic [REG_W-1:0]  regWrite_EX,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              memWrite_E_MEM,
  output logic              MemToReg_MEM,
  output logic              regWrite_E_MEM,
  output logic              mem_read_MEM,
  output logic [DATA_W-1:0] ALU_out_MEM,
  output logic [DATA_W-1:0] mem_Din_MEM,
  output logic [REG_W-1:0]  regWrite_MEM,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic              mw;
    logic              m2r;
    logic              rwe;
    logic              mr;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] din;
    logic [REG_W-1:0]  rd;
  } entry_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  entry_t             main_q, main_d;
  entry_t             skid_q, skid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  entry_t             in_entry;
  logic               push, pop;

  always_comb begin
    in_entry     = '{mw: memWrite_E_EX, m2r: MemToReg_EX, rwe: regWrite_E_EX,
                     mr: mem_read_EX, alu: ALU_out_EX, din: mem_Din_EX,
                     rd: regWrite_EX};
    // Writes to the hard-wired zero register are dropped at capture time.
    in_entry.rwe = regWrite_E_EX & (regWrite_EX != REG_W'(ZERO_REG));

    push        = in_valid & in_ready_q;
    pop         = (state_q != EMPTY) & out_ready;

    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q;

    if ((state_q != EMPTY) && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_d = ONE;
          main_d  = in_entry;
        end
        ONE: begin
          if (push && !pop) begin
            state_d = TWO;
            skid_d  = in_entry;
          end else if (push && pop) begin
            main_d  = in_entry;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end

    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Control bits are masked to bubbles while empty; data keeps its last value.
  assign out_valid      = (state_q != EMPTY);
  assign in_ready       = in_ready_q;
  assign memWrite_E_MEM = main_q.mw  & out_valid;
  assign MemToReg_MEM   = main_q.m2r & out_valid;
  assign regWrite_E_MEM = main_q.rwe & out_valid;
  assign mem_read_MEM   = main_q.mr  & out_valid;
  assign ALU_out_MEM    = main_q.alu;
  assign mem_Din_MEM    = main_q.din;
  assign regWrite_MEM   = main_q.rd;
  assign fwd_valid      = out_valid & main_q.rwe & ~main_q.mr;
  assign fwd_reg        = main_q.rd;
  assign fwd_data       = main_q.alu;
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: directed vector table, saturation sequence, and
// randomized traffic checked against a queue-based reference model.
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        mw, m2r, rwe, mr;
  logic [63:0] alu, din;
  logic [4:0]  rd;
  logic        in_ready, out_valid;
  logic        memWrite_E_MEM, MemToReg_MEM, regWrite_E_MEM, mem_read_MEM;
  logic [63:0] ALU_out_MEM, mem_Din_MEM, fwd_data;
  logic [4:0]  regWrite_MEM, fwd_reg;
  logic        fwd_valid;
  logic [3:0]  stall_cnt;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_pipe #(.DATA_W(64), .REG_W(5), .ZERO_REG(31), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .memWrite_E_EX(mw), .MemToReg_EX(m2r),
    .regWrite_E_EX(rwe), .mem_read_EX(mr), .ALU_out_EX(alu),
    .mem_Din_EX(din), .regWrite_EX(rd), .out_valid(out_valid),
    .out_ready(out_ready), .memWrite_E_MEM(memWrite_E_MEM),
    .MemToReg_MEM(MemToReg_MEM), .regWrite_E_MEM(regWrite_E_MEM),
    .mem_read_MEM(mem_read_MEM), .ALU_out_MEM(ALU_out_MEM),
    .mem_Din_MEM(mem_Din_MEM), .regWrite_MEM(regWrite_MEM),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .stall_cnt(stall_cnt)
  );

  // Reference model: a FIFO of at most two entries plus the last head shown.
  typedef struct packed {
    logic        mw, m2r, rwe, mr;
    logic [63:0] alu, din;
    logic [4:0]  rd;
  } ent_t;

  ent_t m_q[$];
  ent_t m_last = '0;
  bit   m_ready = 1'b1;
  int   m_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit   ov;
    ent_t h;
    ov = (m_q.size() > 0);
    h  = ov ? m_q[0] : '0;
    chk("out_valid", 64'(out_valid), 64'(ov));
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    chk("ctrl", 64'({memWrite_E_MEM, MemToReg_MEM, regWrite_E_MEM, mem_read_MEM}),
        64'({h.mw, h.m2r, h.rwe, h.mr}));
    chk("alu_mem", ALU_out_MEM, m_last.alu);
    chk("din_mem", mem_Din_MEM, m_last.din);
    chk("rd_mem", 64'(regWrite_MEM), 64'(m_last.rd));
    chk("fwd_valid", 64'(fwd_valid), 64'(ov && h.rwe && !h.mr));
    chk("fwd_reg_data", {fwd_data[58:0], fwd_reg}, {m_last.alu[58:0], m_last.rd});
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
  endtask

  task automatic cycle();
    bit   push, pop;
    ent_t e;
    push = in_valid && m_ready;
    pop  = (m_q.size() > 0) && out_ready;
    if (reset) begin
      m_q.delete();
      m_ready = 1'b1;
      m_cnt   = 0;
      m_last  = '0;
    end else begin
      if ((m_q.size() > 0) && !out_ready && m_cnt < 15) m_cnt++;
      if (flush) begin
        m_q.delete();
      end else begin
        if (pop) void'(m_q.pop_front());
        if (push) begin
          e = '{mw: mw, m2r: m2r, rwe: rwe && (rd != 5'd31), mr: mr,
                alu: alu, din: din, rd: rd};
          m_q.push_back(e);
        end
      end
      m_ready = (m_q.size() < 2);
    end
    if (m_q.size() > 0) m_last = m_q[0];
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic        rst, fl, iv, ordy, rwe, mr;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic        e_ov, e_ir, e_rwe, e_fv;
    logic [63:0] e_alu;
    logic [4:0]  e_freg;
    logic [3:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst_i, fl_i, iv_i, or_i, rwe_i, mr_i,
                              input logic [63:0] alu_i, input logic [4:0] rd_i,
                              input logic ov_e, ir_e, rwe_e, fv_e,
                              input logic [63:0] alu_e, input logic [4:0] freg_e,
                              input logic [3:0] cnt_e);
    vec_t v;
    v = '{rst_i, fl_i, iv_i, or_i, rwe_i, mr_i, alu_i, rd_i,
          ov_e, ir_e, rwe_e, fv_e, alu_e, freg_e, cnt_e};
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            rst fl iv or rwe mr  alu    rd  | ov ir rwe fv  alu    freg cnt
    tbl[0]  = mk(1, 0, 0, 1, 0, 0, 64'h00, 0,  0, 1, 0, 0, 64'h00, 0,  0);
    tbl[1]  = mk(0, 0, 1, 1, 1, 0, 64'h10, 3,  1, 1, 1, 1, 64'h10, 3,  0);
    tbl[2]  = mk(0, 0, 0, 1, 0, 0, 64'h00, 0,  0, 1, 0, 0, 64'h10, 3,  0);
    tbl[3]  = mk(0, 0, 1, 0, 1, 0, 64'h20, 5,  1, 1, 1, 1, 64'h20, 5,  0);
    tbl[4]  = mk(0, 0, 1, 0, 1, 0, 64'h30, 6,  1, 0, 1, 1, 64'h20, 5,  1);
    tbl[5]  = mk(0, 0, 1, 0, 1, 0, 64'h40, 9,  1, 0, 1, 1, 64'h20, 5,  2);
    tbl[6]  = mk(0, 0, 0, 1, 0, 0, 64'h00, 0,  1, 1, 1, 1, 64'h30, 6,  2);
    tbl[7]  = mk(0, 0, 0, 1, 0, 0, 64'h00, 0,  0, 1, 0, 0, 64'h30, 6,  2);
    tbl[8]  = mk(0, 0, 1, 0, 1, 0, 64'h50, 31, 1, 1, 0, 0, 64'h50, 31, 2);
    tbl[9]  = mk(0, 0, 1, 1, 1, 1, 64'h60, 4,  1, 1, 1, 0, 64'h60, 4,  2);
    tbl[10] = mk(0, 0, 1, 0, 1, 0, 64'h70, 7,  1, 0, 1, 0, 64'h60, 4,  3);
    tbl[11] = mk(0, 1, 1, 0, 1, 0, 64'h80, 8,  0, 1, 0, 0, 64'h60, 4,  4);
    tbl[12] = mk(0, 0, 1, 0, 1, 0, 64'h90, 8,  1, 1, 1, 1, 64'h90, 8,  4);
    tbl[13] = mk(1, 1, 1, 0, 1, 0, 64'hA0, 2,  0, 1, 0, 0, 64'h00, 0,  0);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mw = 1'b0; m2r = 1'b0; rwe = 1'b0; mr = 1'b0; alu = '0; din = '0; rd = '0;

    foreach (tbl[i]) begin
      reset = tbl[i].rst; flush = tbl[i].fl; in_valid = tbl[i].iv;
      out_ready = tbl[i].ordy; rwe = tbl[i].rwe; mr = tbl[i].mr;
      alu = tbl[i].alu; din = ~tbl[i].alu; rd = tbl[i].rd;
      mw = tbl[i].iv & ~tbl[i].mr; m2r = tbl[i].mr;
      cycle();
      chk("tbl_out_valid", 64'(out_valid), 64'(tbl[i].e_ov));
      chk("tbl_in_ready", 64'(in_ready), 64'(tbl[i].e_ir));
      chk("tbl_regwrite_e", 64'(regWrite_E_MEM), 64'(tbl[i].e_rwe));
      chk("tbl_fwd_valid", 64'(fwd_valid), 64'(tbl[i].e_fv));
      chk("tbl_alu", ALU_out_MEM, tbl[i].e_alu);
      chk("tbl_fwd_reg", 64'(fwd_reg), 64'(tbl[i].e_freg));
      chk("tbl_stall_cnt", 64'(stall_cnt), 64'(tbl[i].e_cnt));
    end

    // Stall counter saturation: one held entry, sink stalled for 2^4+5 cycles.
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    rwe = 1'b1; mr = 1'b0; alu = 64'hBEEF; din = 64'h1234; rd = 5'd10;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 21; i++) cycle();
    chk("sat_stall_cnt", 64'(stall_cnt), 64'd15);
    chk("sat_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    cycle();
    chk("sat_hold_after_pop", 64'(stall_cnt), 64'd15);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 9) < 6);
      mw        = $urandom_range(0, 1) == 1;
      m2r       = $urandom_range(0, 1) == 1;
      rwe       = ($urandom_range(0, 3) != 0);
      mr        = ($urandom_range(0, 3) == 0);
      alu       = {$urandom, $urandom};
      din       = {$urandom, $urandom};
      rd        = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
